// File: rtl/lm07_pkg.sv
// lm07_pkg: shared constants and types for the LM07-style SPI responder.
// Holds the frame width, command codes, read-frame tail and FSM state enum.
package lm07_pkg;

    // Every SPI phase (read and command write) is this many SCK clocks long.
    localparam int FRAME_BITS = 16;

    // Command words recognised at the end of the write phase.
    localparam logic [FRAME_BITS-1:0] CMD_SHUTDOWN = 16'hFFFF;
    localparam logic [FRAME_BITS-1:0] CMD_NORMAL   = 16'h0000;

    // Bits appended below the temperature in a normal-mode read frame.
    localparam logic [2:0] TAIL_BITS = 3'b111;

    // Responder frame sequencing.
    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        HOLD
    } state_t;

    // Next command shift-register value: shift left, new bit enters at LSB.
    function automatic logic [FRAME_BITS-1:0] shift_in(
        input logic [FRAME_BITS-1:0] sr,
        input logic                  bit_in
    );
        return (sr << 1) | {{(FRAME_BITS-1){1'b0}}, bit_in};
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: multi-flop synchronizer for one asynchronous pad input.
// Ports: clk, rst (async, active-high), d (pad), q (synchronized level),
//        rise / fall (1-cycle pulses on q transitions).
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;

    // All flops clear to 0. For CS this means a select that is already low
    // when reset ends produces no falling edge, so that frame is skipped
    // until CS has been high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= STAGES'({chain, d});
            q_d   <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/lm07_responder.sv
// lm07_responder: SPI slave emulating an LM07-style temperature sensor.
// Ports: SYSCLK/RST (async high), CS/SCK/SIO_I from master, SIO_O/SIO_OE
//        to pad, temp_in, shutdown, frame_done and cmd_valid pulses.
module lm07_responder
    import lm07_pkg::*;
#(
    parameter int              TEMP_BITS   = 13,
    parameter int              SYNC_STAGES = 2,
    parameter logic [15:0]     ID_CODE     = 16'h800F
) (
    input  logic                 SYSCLK,
    input  logic                 RST,
    input  logic                 CS,
    input  logic                 SCK,
    input  logic                 SIO_I,
    output logic                 SIO_O,
    output logic                 SIO_OE,
    input  logic [TEMP_BITS-1:0] temp_in,
    output logic                 shutdown,
    output logic                 frame_done,
    output logic                 cmd_valid
);

    logic cs_q;
    logic cs_rise;
    logic cs_fall;
    logic sck_q;
    logic sck_rise;
    logic sck_fall;
    logic sio_q;
    logic sio_rise;
    logic sio_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (SYSCLK),
        .rst  (RST),
        .d    (CS),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (SYSCLK),
        .rst  (RST),
        .d    (SCK),
        .q    (sck_q),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sio_sync (
        .clk  (SYSCLK),
        .rst  (RST),
        .d    (SIO_I),
        .q    (sio_q),
        .rise (sio_rise),
        .fall (sio_fall)
    );

    // Only the edge pulses of CS/SCK and the level of SIO_I are needed.
    logic unused_sync;
    assign unused_sync = cs_q ^ sck_q ^ sio_rise ^ sio_fall;

    state_t                state;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] cmd_sr;
    logic [FRAME_BITS-1:0] frame_word;
    logic [FRAME_BITS-1:0] cmd_next;

    // Normal frame: temperature MSB-aligned, remaining low bits all ones
    // (TAIL_BITS for the 13-bit sensor).
    always_comb begin
        frame_word = {FRAME_BITS{1'b1}};
        frame_word[FRAME_BITS-1 -: TEMP_BITS] = temp_in;
        if (shutdown) begin
            frame_word = ID_CODE;
        end
    end

    assign cmd_next = shift_in(cmd_sr, sio_q);

    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= 5'd0;
            shreg      <= '0;
            cmd_sr     <= '0;
            SIO_O      <= 1'b0;
            SIO_OE     <= 1'b0;
            shutdown   <= 1'b0;
            frame_done <= 1'b0;
            cmd_valid  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cmd_valid  <= 1'b0;
            // CS release aborts whatever is in flight, including an SCK
            // edge seen in the same cycle.
            if (cs_rise) begin
                state   <= IDLE;
                bit_cnt <= 5'd0;
                SIO_O   <= 1'b0;
                SIO_OE  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            shreg   <= frame_word;
                            cmd_sr  <= '0;
                            SIO_O   <= frame_word[FRAME_BITS-1];
                            SIO_OE  <= 1'b1;
                            bit_cnt <= 5'd0;
                            state   <= READ;
                        end
                    end
                    READ: begin
                        if (sck_rise) begin
                            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                                // Last read bit sampled by the master;
                                // the pad stays driven until the next fall.
                                frame_done <= 1'b1;
                                bit_cnt    <= 5'd0;
                                state      <= WRITE;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end else if (sck_fall) begin
                            shreg <= shreg << 1;
                            SIO_O <= shreg[FRAME_BITS-2];
                        end
                    end
                    WRITE: begin
                        if (sck_fall) begin
                            SIO_OE <= 1'b0;
                            SIO_O  <= 1'b0;
                        end
                        if (sck_rise) begin
                            cmd_sr <= cmd_next;
                            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                                cmd_valid <= 1'b1;
                                bit_cnt   <= 5'(FRAME_BITS);
                                state     <= HOLD;
                                case (cmd_next)
                                    CMD_SHUTDOWN: shutdown <= 1'b1;
                                    CMD_NORMAL:   shutdown <= 1'b0;
                                    default:      shutdown <= shutdown;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    HOLD: begin
                        SIO_OE <= 1'b0;
                        SIO_O  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lm07_responder.sv
// tb_lm07_responder: directed bench for lm07_responder acting as SPI master.
// Table of full read/write frames plus hand sequences for abort and reset.
module tb_lm07_responder;

    logic        SYSCLK;
    logic        RST;
    logic        CS;
    logic        SCK;
    logic        SIO_I;
    logic        SIO_O;
    logic        SIO_OE;
    logic [12:0] temp_in;
    logic        shutdown;
    logic        frame_done;
    logic        cmd_valid;

    lm07_responder dut (
        .SYSCLK     (SYSCLK),
        .RST        (RST),
        .CS         (CS),
        .SCK        (SCK),
        .SIO_I      (SIO_I),
        .SIO_O      (SIO_O),
        .SIO_OE     (SIO_OE),
        .temp_in    (temp_in),
        .shutdown   (shutdown),
        .frame_done (frame_done),
        .cmd_valid  (cmd_valid)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int cv_cnt   = 0;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge SYSCLK) begin
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (cmd_valid)  cv_cnt = cv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Master samples SIO_O just before each SCK rise (SCK period 100 ns).
    task automatic read_bits(input int n, output logic [15:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            #40;
            w = {w[14:0], SIO_O};
            #10;
            SCK = 1'b1;
            #50;
            SCK = 1'b0;
        end
    endtask

    // Master changes SIO_I while SCK is low, responder samples on rise.
    task automatic write_bits(input int n, input logic [15:0] w);
        for (int i = 0; i < n; i++) begin
            SIO_I = w[15-i];
            #50;
            SCK = 1'b1;
            #50;
            SCK = 1'b0;
        end
        SIO_I = 1'b0;
    endtask

    task automatic cs_high();
        #50;
        CS = 1'b1;
        #100;
    endtask

    typedef struct {
        logic [12:0] temp;
        logic [15:0] cmd;
        logic [15:0] exp_word;
        logic        exp_sd;
    } vec_t;

    vec_t vecs[8];

    logic [15:0] word;
    int          fd0;
    int          cv0;

    initial begin
        vecs[0] = '{13'h0190, 16'h1234, 16'h0C87, 1'b0};
        vecs[1] = '{13'h1E70, 16'hFFFF, 16'hF387, 1'b1};
        vecs[2] = '{13'h0190, 16'h1234, 16'h800F, 1'b1};
        vecs[3] = '{13'h1E70, 16'h0000, 16'h800F, 1'b0};
        vecs[4] = '{13'h1E70, 16'h5555, 16'hF387, 1'b0};
        vecs[5] = '{13'h0000, 16'h0000, 16'h0007, 1'b0};
        vecs[6] = '{13'h0FFF, 16'hFFFE, 16'h7FFF, 1'b0};
        vecs[7] = '{13'h1000, 16'h8000, 16'h8007, 1'b0};

        RST     = 1'b1;
        CS      = 1'b1;
        SCK     = 1'b0;
        SIO_I   = 1'b0;
        temp_in = '0;
        #20;
        check("reset_outputs",
              {27'd0, SIO_O, SIO_OE, shutdown, frame_done, cmd_valid},
              32'd0);
        #10;
        RST = 1'b0;
        #100;

        for (int v = 0; v < 8; v++) begin
            temp_in = vecs[v].temp;
            fd0 = fd_cnt;
            cv0 = cv_cnt;
            CS = 1'b0;
            read_bits(16, word);
            // Temperature changes after the snapshot must not matter.
            temp_in = ~vecs[v].temp;
            check($sformatf("v%0d_read", v), {16'd0, word},
                  {16'd0, vecs[v].exp_word});
            check($sformatf("v%0d_frame_done", v), fd_cnt - fd0, 1);
            write_bits(16, vecs[v].cmd);
            check($sformatf("v%0d_oe_after_read", v), {31'd0, SIO_OE}, 0);
            check($sformatf("v%0d_cmd_valid", v), cv_cnt - cv0, 1);
            check($sformatf("v%0d_shutdown", v), {31'd0, shutdown},
                  {31'd0, vecs[v].exp_sd});
            cs_high();
        end

        // Abort after 5 read bits, then a fresh frame restarts at the MSB.
        temp_in = 13'h0190;
        fd0 = fd_cnt;
        cv0 = cv_cnt;
        CS = 1'b0;
        read_bits(5, word);
        check("abort_bits", {16'd0, word}, 32'h0000_0001);
        #50;
        CS = 1'b1;
        #30;
        check("abort_oe_low", {31'd0, SIO_OE}, 0);
        #100;
        check("abort_no_frame_done", fd_cnt - fd0, 0);
        temp_in = 13'h1E70;
        CS = 1'b0;
        read_bits(16, word);
        check("restart_read", {16'd0, word}, 32'h0000_F387);
        check("restart_frame_done", fd_cnt - fd0, 1);
        cs_high();
        check("restart_no_cmd", cv_cnt - cv0, 0);

        // Partial command of ones is discarded.
        temp_in = 13'h0190;
        cv0 = cv_cnt;
        CS = 1'b0;
        read_bits(16, word);
        check("pw_read", {16'd0, word}, 32'h0000_0C87);
        write_bits(10, 16'hFFFF);
        cs_high();
        check("pw_no_cmd_valid", cv_cnt - cv0, 0);
        check("pw_shutdown", {31'd0, shutdown}, 0);

        // Reset at bit 8 of a read; the lost frame is not answered.
        CS = 1'b0;
        read_bits(8, word);
        RST = 1'b1;
        #1;
        check("rst_outputs",
              {27'd0, SIO_O, SIO_OE, shutdown, frame_done, cmd_valid},
              32'd0);
        #9;
        RST = 1'b0;
        fd0 = fd_cnt;
        read_bits(4, word);
        check("rst_no_oe", {31'd0, SIO_OE}, 0);
        check("rst_no_frame_done", fd_cnt - fd0, 0);
        cs_high();
        // SCK activity while deselected is ignored.
        for (int i = 0; i < 20; i++) begin
            SCK = 1'b1;
            #50;
            SCK = 1'b0;
            #50;
        end
        check("idle_sck_no_oe", {31'd0, SIO_OE}, 0);
        check("idle_sck_no_frame_done", fd_cnt - fd0, 0);
        temp_in = 13'h1E70;
        CS = 1'b0;
        read_bits(16, word);
        check("rst_next_read", {16'd0, word}, 32'h0000_F387);
        check("rst_next_frame_done", fd_cnt - fd0, 1);
        cs_high();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
